// File: rtl/vga_timing_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_engine
// Purpose  : Pixel divider, fetch-stage raster counters and a FETCH_LAT-tick
//            display pipeline. Optional macro: VGA_TEST_PATTERN_EN.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_engine #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int H_POL     = 1,
  parameter int V_POL     = 1,
  parameter int PIX_DIV   = 1,
  parameter int FETCH_LAT = 1,
  parameter int CBITS     = 4,
  parameter int CNT_W     = 11
) (
  input  logic               clk,
  input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  input  logic [3*CBITS-1:0] pix_data,
  output logic [CNT_W-1:0]   fetch_x,
  output logic [CNT_W-1:0]   fetch_y,
  output logic               fetch_valid,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CBITS-1:0]   r,
  output logic [CBITS-1:0]   g,
  output logic [CBITS-1:0]   b
);

  localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int C_DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0]   C_X_LAST   = CNT_W'(C_H_TOTAL - 1);
  localparam logic [CNT_W-1:0]   C_Y_LAST   = CNT_W'(C_V_TOTAL - 1);
  localparam logic [CNT_W-1:0]   C_X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]   C_Y_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]   C_HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0]   C_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0]   C_VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0]   C_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic               C_HS_ON    = (H_POL != 0);
  localparam logic               C_VS_ON    = (V_POL != 0);

  logic [C_DIV_W-1:0] r_div;
  logic               w_tick;
  logic               w_x_last;
  logic               w_y_last;
  logic               w_hs_f;
  logic               w_vs_f;
  logic               w_last_v;
  logic               w_last_hs;
  logic               w_last_vs;
  logic [3*CBITS-1:0] w_rgb;
`ifdef VGA_TEST_PATTERN_EN
  logic [CNT_W-1:0]   w_last_x;
`endif

  // Gated by reset so no tick is ever seen while the engine is held
  assign w_tick   = reset && (r_div == C_DIV_LAST);
  assign pix_tick = w_tick;

  always_ff @(posedge clk) begin
    if (!reset)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  assign w_x_last = (fetch_x == C_X_LAST);
  assign w_y_last = (fetch_y == C_Y_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_x <= '0;
      fetch_y <= '0;
    end else if (w_tick) begin
      if (w_x_last) begin
        fetch_x <= '0;
        fetch_y <= w_y_last ? '0 : fetch_y + 1'b1;
      end else begin
        fetch_x <= fetch_x + 1'b1;
      end
    end
  end

  assign fetch_valid = (fetch_x < C_X_ACT) && (fetch_y < C_Y_ACT);
  assign w_hs_f      = (fetch_x >= C_HS_BEG) && (fetch_x < C_HS_END);
  assign w_vs_f      = (fetch_y >= C_VS_BEG) && (fetch_y < C_VS_END);
  assign line_start  = w_tick && w_x_last;
  assign frame_start = w_tick && w_x_last && w_y_last;

  // The output registers are the final pipeline stage, so only FETCH_LAT-1
  // intermediate stages sit between the counters and them.
  generate
    if (FETCH_LAT == 1) begin : g_lat1
      assign w_last_v  = fetch_valid;
      assign w_last_hs = w_hs_f;
      assign w_last_vs = w_vs_f;
`ifdef VGA_TEST_PATTERN_EN
      assign w_last_x  = fetch_x;
`endif
    end else begin : g_pipe
      logic [FETCH_LAT-2:0] r_v;
      logic [FETCH_LAT-2:0] r_hs;
      logic [FETCH_LAT-2:0] r_vs;
`ifdef VGA_TEST_PATTERN_EN
      logic [CNT_W-1:0]     r_x [FETCH_LAT-1];
`endif
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_v  <= '0;
          r_hs <= '0;
          r_vs <= '0;
`ifdef VGA_TEST_PATTERN_EN
          for (int i = 0; i < FETCH_LAT - 1; i++) r_x[i] <= '0;
`endif
        end else if (w_tick) begin
          r_v[0]  <= fetch_valid;
          r_hs[0] <= w_hs_f;
          r_vs[0] <= w_vs_f;
`ifdef VGA_TEST_PATTERN_EN
          r_x[0]  <= fetch_x;
`endif
          for (int i = 1; i < FETCH_LAT - 1; i++) begin
            r_v[i]  <= r_v[i-1];
            r_hs[i] <= r_hs[i-1];
            r_vs[i] <= r_vs[i-1];
`ifdef VGA_TEST_PATTERN_EN
            r_x[i]  <= r_x[i-1];
`endif
          end
        end
      end
      assign w_last_v  = r_v[FETCH_LAT-2];
      assign w_last_hs = r_hs[FETCH_LAT-2];
      assign w_last_vs = r_vs[FETCH_LAT-2];
`ifdef VGA_TEST_PATTERN_EN
      assign w_last_x  = r_x[FETCH_LAT-2];
`endif
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  localparam int C_BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [CNT_W-1:0] w_bar;
  logic [2:0]       w_idx;

  // Columns past the eighth full bar fold into the last (black) bar
  assign w_bar = w_last_x / CNT_W'(C_BAR_W);
  assign w_idx = (w_bar > CNT_W'(7)) ? 3'd0 : (3'd7 - w_bar[2:0]);

  always_comb begin
    w_rgb = '0;
    if (w_last_v) begin
      if (pattern_sel) w_rgb = {{CBITS{w_idx[0]}}, {CBITS{w_idx[1]}}, {CBITS{w_idx[2]}}};
      else             w_rgb = pix_data;
    end
  end
`else
  assign w_rgb = w_last_v ? pix_data : '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      de    <= 1'b0;
      hsync <= ~C_HS_ON;
      vsync <= ~C_VS_ON;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else if (w_tick) begin
      de    <= w_last_v;
      hsync <= w_last_hs ? C_HS_ON : ~C_HS_ON;
      vsync <= w_last_vs ? C_VS_ON : ~C_VS_ON;
      r     <= w_rgb[CBITS-1:0];
      g     <= w_rgb[2*CBITS-1:CBITS];
      b     <= w_rgb[3*CBITS-1:2*CBITS];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_engine
// Purpose  : Self-checking bench: small raster, PIX_DIV=3, FETCH_LAT=3.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_engine;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int PD = 3, FL = 3, CW = 11;
  localparam logic HP = 1'b1, VP = 1'b0;

  typedef struct packed {
    logic          v;
    logic          hs;
    logic          vs;
    logic [CW-1:0] x;
  } rec_t;

  typedef struct {
    int          mode;
    logic [11:0] pd;
    logic [3:0]  er;
    logic [3:0]  eg;
    logic [3:0]  eb;
    int          cycles;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [11:0]   pix_data;
  logic [CW-1:0] fetch_x, fetch_y;
  logic          fetch_valid, pix_tick, line_start, frame_start;
  logic          hsync, vsync, de;
  logic [3:0]    r, g, b;

  int            total = 0;
  int            bad = 0;
  int            mode = 0;
  logic [11:0]   pd_const = '0;
  logic [3:0]    er = '0, eg = '0, eb = '0;
  int            m_div = 0, m_x = 0, m_y = 0;
  rec_t          q[$];
  logic [14:0]   cur_disp;
  logic [CW-1:0] mem0 = '0, mem1 = '0;
  vec_t          tbl[5];

  always #5 clk = ~clk;

  // Frame-buffer stand-in: address registered twice on pixel ticks
  always @(posedge clk) begin
    if (pix_tick) begin
      mem0 <= fetch_x;
      mem1 <= mem0;
    end
  end
  assign pix_data = (mode == 1) ? {1'b0, mem1} : pd_const;

  vga_timing_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1), .V_POL(0), .PIX_DIV(PD), .FETCH_LAT(FL),
    .CBITS(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data),
    .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_valid(fetch_valid),
    .pix_tick(pix_tick), .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  function automatic rec_t mk_rec(input int x, input int y);
    rec_t e;
    e.v  = (x < HA) && (y < VA);
    e.hs = (x >= HA + HFP) && (x < HA + HFP + HS);
    e.vs = (y >= VA + VFP) && (y < VA + VFP + VS);
    e.x  = CW'(x);
    return e;
  endfunction

  // {de, hsync, vsync, b, g, r}
  function automatic logic [14:0] exp_disp(input rec_t e);
    logic [11:0] c;
    if (!e.v)           c = '0;
    else if (mode == 0) c = {eb, eg, er};
    else                c = {1'b0, e.x};
    return {e.v, e.hs ? HP : ~HP, e.vs ? VP : ~VP, c};
  endfunction

  // One clock: advance the reference model, then check every DUT output
  task automatic step();
    logic rs;
    logic ck;
    rs = reset;
    @(posedge clk);
    #1;
    if (!rs) begin
      m_div = 0; m_x = 0; m_y = 0;
      q.delete();
      for (int i = 0; i < FL - 1; i++) q.push_back(rec_t'(0));
      cur_disp = exp_disp(rec_t'(0));
    end else if (m_div == PD - 1) begin
      q.push_back(mk_rec(m_x, m_y));
      cur_disp = exp_disp(q.pop_front());
      m_div = 0;
      if (m_x == HT - 1) begin
        m_x = 0;
        m_y = (m_y == VT - 1) ? 0 : m_y + 1;
      end else begin
        m_x++;
      end
    end else begin
      m_div++;
    end
    ck = reset && (m_div == PD - 1);
    cmp("fetch", 32'({pix_tick, line_start, frame_start, fetch_valid, fetch_x, fetch_y}),
        32'({ck, ck && (m_x == HT - 1), ck && (m_x == HT - 1) && (m_y == VT - 1),
             (m_x < HA) && (m_y < VA), CW'(m_x), CW'(m_y)}));
    cmp("disp", 32'({de, hsync, vsync, b, g, r}), 32'(cur_disp));
  endtask

  task automatic check_reset_state(input string tag);
    cmp({tag, "_ctl"}, 32'({pix_tick, line_start, frame_start, de, hsync, vsync, b, g, r}),
        32'({6'b000001, 12'h000}));
    cmp({tag, "_cnt"}, 32'({fetch_x, fetch_y}), 32'(0));
  endtask

  // Called right after a reset edge: releases reset and times key events
  task automatic measure_release(input string tag);
    int n, t_tick, t_hr, t_hf, t_fs;
    logic prev_hs;
    n = 0; t_tick = -1; t_hr = -1; t_hf = -1; t_fs = -1;
    prev_hs = hsync;
    reset = 1'b1;
    while (t_fs < 0 && n < 2000) begin
      step();
      n++;
      if (pix_tick && t_tick < 0) t_tick = n;
      if (hsync && !prev_hs && t_hr < 0) t_hr = n;
      if (!hsync && prev_hs && t_hr >= 0 && t_hf < 0) t_hf = n;
      if (frame_start) t_fs = n;
      prev_hs = hsync;
    end
    cmp({tag, "_first_tick"}, 32'(t_tick), 32'(PD - 1));
    cmp({tag, "_hsync_rise"}, 32'(t_hr), 32'(PD - 1 + PD * (HA + HFP + FL - 1) + 1));
    cmp({tag, "_hsync_width"}, 32'(t_hf - t_hr), 32'(PD * HS));
    cmp({tag, "_frame_start"}, 32'(t_fs), 32'(PD * HT * VT - 1));
  endtask

  initial begin
    int n;
    tbl[0] = '{0, 12'hABC, 4'hC, 4'hB, 4'hA, 600};
    tbl[1] = '{0, 12'h123, 4'h3, 4'h2, 4'h1, 300};
    tbl[2] = '{1, 12'h000, 4'h0, 4'h0, 4'h0, 700};
    tbl[3] = '{0, 12'hFFF, 4'hF, 4'hF, 4'hF, 250};
    tbl[4] = '{0, 12'h5A0, 4'h0, 4'hA, 4'h5, 250};

    reset = 1'b0;
    repeat (3) step();
    check_reset_state("rst");
    measure_release("boot");

    for (int i = 0; i < 5; i++) begin
      mode     = tbl[i].mode;
      pd_const = tbl[i].pd;
      er       = tbl[i].er;
      eg       = tbl[i].eg;
      eb       = tbl[i].eb;
      repeat (tbl[i].cycles) step();
    end

    // Single-cycle reset pulse while fetching (10,3)
    n = 0;
    while (!(fetch_x == CW'(10) && fetch_y == CW'(3)) && n < 1000) begin
      step();
      n++;
    end
    cmp("reach_10_3", 32'({fetch_x, fetch_y}), 32'({CW'(10), CW'(3)}));
    reset = 1'b0;
    step();
    check_reset_state("pulse");
    measure_release("pulse");
    repeat (100) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_engine.md
VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

Interface
REQ-001 Parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 40, 128, 88: horizontal porches and sync in pixels; H_TOTAL = sum of the four (1056).
REQ-003 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 600, 1, 4, 23: the same in lines; V_TOTAL = 628.
REQ-004 Parameters H_POL, V_POL, default 1: active level of hsync/vsync.
REQ-005 Parameter PIX_DIV, default 1, range 1..16: clk cycles per pixel tick.
REQ-006 Parameter FETCH_LAT, default 1, range 1..4: pixel ticks from fetch address to pix_data valid.
REQ-007 Parameter CBITS, default 4: bits per colour channel; CNT_W, default 11: counter width.
REQ-008 clk  in  1  clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-low.
REQ-010 pix_data  in  3*CBITS  pixel; [CBITS-1:0]=r, next CBITS=g, top CBITS=b.
REQ-011 fetch_x, fetch_y  out  CNT_W  fetch-stage h/v counters.
REQ-012 fetch_valid  out  1  fetch_x<H_ACTIVE and fetch_y<V_ACTIVE.
REQ-013 pix_tick  out  1  high one clk cycle per pixel tick.
REQ-014 line_start, frame_start  out  1  one-clk pulses (see REQ-021).
REQ-015 hsync, vsync, de  out  1  display-stage timing.
REQ-016 r, g, b  out  CBITS each  display colour.

Function
REQ-017 Divider counts 0..PIX_DIV-1; pix_tick high when divider = PIX_DIV-1, then divider wraps to 0; PIX_DIV=1 gives pix_tick high every cycle.
REQ-018 On pix_tick: fetch_x increments; at H_TOTAL-1 it wraps to 0 and fetch_y increments; fetch_y at V_TOTAL-1 wraps to 0 on the same tick. Counters hold between ticks.
REQ-019 Fetch-stage sync: hs_f active when H_ACTIVE+H_FP <= fetch_x < H_ACTIVE+H_FP+H_SYNC; vs_f likewise on fetch_y with V parameters.
REQ-020 {fetch_valid, hs_f, vs_f, fetch_x} pass through a FETCH_LAT-deep shift pipeline advanced only on pix_tick; de/hsync/vsync are registered from the last stage; hsync = H_POL when active, else !H_POL (vsync likewise).
REQ-021 line_start high in the pix_tick cycle in which fetch_x wraps to 0; frame_start additionally requires fetch_y wrapping to 0; otherwise both are 0.
REQ-022 On pix_tick, r/g/b register pix_data if last-stage valid is 1, else 0; blanking never passes pix_data.
REQ-023 Latency: fetch address to matching de/rgb/sync = exactly FETCH_LAT pixel ticks; outputs change only in pix_tick cycles.
REQ-024 Parameter sums exceeding 2^CNT_W-1 are illegal; behaviour is unspecified.

Reset
REQ-025 While reset=0: divider, fetch_x, fetch_y = 0; pipeline cleared (valid=0, syncs inactive); de=0; r/g/b=0; hsync=!H_POL; vsync=!V_POL; pix_tick, line_start, frame_start = 0.
REQ-026 Reset asserted mid-frame takes effect on the next clk edge; after release, the first pix_tick occurs PIX_DIV cycles later and timing restarts from (0,0).

Configuration
REQ-027 With VGA_TEST_PATTERN_EN defined: input pattern_sel (1 bit) is added; when 1, active pixels show 8 vertical bars of width H_ACTIVE/8 computed from the delayed x; bar k shows idx=7-k (pixels beyond 8*width use k=7); r={CBITS{idx[2]}}, g={CBITS{idx[1]}}, b={CBITS{idx[0]}}; blanking stays 0.
REQ-028 Without VGA_TEST_PATTERN_EN: no pattern_sel port; r/g/b always follow REQ-022.

Verification
REQ-029 Defaults, PIX_DIV=1, release reset at cycle 0 -> first hsync rise (H_POL=1) at cycle 840+1, high for 128 cycles, period 1056.
REQ-030 Defaults -> vsync high for 4224 cycles; frame_start period 663168 cycles; de high 800 of every 1056 cycles for 600 lines.
REQ-031 pix_data=12'hABC held -> r=4'hC, g=4'hB, b=4'hA when de=1; r=g=b=0 when de=0.
REQ-032 PIX_DIV=3, FETCH_LAT=3, memory model returning x[11:0] three ticks after fetch -> outputs update every 3rd cycle; r/g/b equal the displayed x; line period 3168 cycles.
REQ-033 Reset pulse of 1 cycle at fetch (400,300) -> next cycle all outputs at REQ-025 values; first frame_start after release occurs 663168 cycles later.
REQ-034 VGA_TEST_PATTERN_EN, pattern_sel=1 -> display x=0..99 white (all F), x=700..799 black, x=100 yellow (r=g=F, b=0).
